// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC and fetch sequencing (sequential/redirect/stall/halt) with sticky fault trapping
module fetch_pc_unit #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] target,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             fault,
    output logic [WIDTH-1:0] fault_pc,
    output logic [31:0]      fetch_count
);
    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;
    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(DEPTH) << 2;
    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_fault;
    logic [WIDTH-1:0] r_fault_pc;
    logic [31:0]      r_fetch_count;
    logic [WIDTH-1:0] w_pc_plus4;
    logic             w_tgt_ok;
    logic             w_seq_ok;
    logic [31:0]      w_cnt_next;
    // next sequential address, legality of both candidate addresses, saturating count
    always_comb begin
        w_pc_plus4 = r_pc + WIDTH'(4);
        w_tgt_ok   = (target[1:0] == 2'b00) && ({1'b0, target} < LIMIT);
        w_seq_ok   = {1'b0, w_pc_plus4} < LIMIT;
        w_cnt_next = r_fetch_count + 32'(r_fetch_count != '1);
    end
    // PC/state sequencer: halt > redirect > stall > sequential while running; fault is terminal until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= WIDTH'(RESET_PC);
            r_fault       <= 1'b0;
            r_fault_pc    <= '0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (halt) begin
                        r_state <= HALTED;
                    end else if (redirect) begin
                        if (w_tgt_ok) begin
                            r_pc          <= target;
                            r_fetch_count <= w_cnt_next;
                        end else begin
                            r_state    <= FAULT;
                            r_fault    <= 1'b1;
                            r_fault_pc <= target;
                        end
                    end else if (!stall) begin
                        if (w_seq_ok) begin
                            r_pc          <= w_pc_plus4;
                            r_fetch_count <= w_cnt_next;
                        end else begin
                            r_state    <= FAULT;
                            r_fault    <= 1'b1;
                            r_fault_pc <= w_pc_plus4;
                        end
                    end
                end
                HALTED: r_state <= (resume && !halt) ? RUN : HALTED;
                default: r_state <= FAULT;
            endcase
        end
    end
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = (r_state == RUN) && !stall;
    assign fault       = r_fault;
    assign fault_pc    = r_fault_pc;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors with a queued scoreboard checked by an independent monitor
module tb_fetch_pc_unit;
    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        f;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n, stall, redirect, halt, resume;
    logic [31:0] target;
    logic [31:0] pc, pc_plus4, fault_pc, fetch_count;
    logic        fetch_valid, fault;
    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    fetch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .target(target),
        .halt(halt), .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
        end
    endtask
    // applies one cycle of inputs and queues the outputs expected during that cycle
    task automatic drive(input logic rn, input logic st, input logic rd, input logic [31:0] tg,
                         input logic h, input logic r, input logic [31:0] epc, input logic efv,
                         input logic ef, input logic [31:0] efpc, input logic [31:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; stall = st; redirect = rd; target = tg; halt = h; resume = r;
        e.pc = epc; e.fv = efv; e.f = ef; e.fpc = efpc; e.cnt = ecnt;
        q.push_back(e);
    endtask
    // monitor: compares every queued expectation against the DUT mid-cycle
    int step = 0;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc", step, pc, e.pc);
            chk("pc_plus4", step, pc_plus4, e.pc + 32'd4);
            chk("fetch_valid", step, 32'(fetch_valid), 32'(e.fv));
            chk("fault", step, 32'(fault), 32'(e.f));
            chk("fault_pc", step, fault_pc, e.fpc);
            chk("fetch_count", step, fetch_count, e.cnt);
            step++;
        end
    end
    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; target = '0; halt = 1'b0; resume = 1'b0;
        repeat (2) @(posedge clk);
        //    rn st rd target      h  r  pc          fv f  fault_pc    cnt
        drive(1, 0, 0, 32'h0,     0, 0, 32'h0,     1, 0, 32'h0,     0);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h4,     1, 0, 32'h0,     1);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h8,     1, 0, 32'h0,     2);
        drive(1, 0, 0, 32'h0,     0, 0, 32'hC,     1, 0, 32'h0,     3);
        drive(0, 0, 0, 32'h0,     0, 0, 32'h10,    1, 0, 32'h0,     4);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h0,     1, 0, 32'h0,     0);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h4,     1, 0, 32'h0,     1);
        drive(1, 1, 1, 32'h100,   0, 0, 32'h8,     0, 0, 32'h0,     2);
        drive(1, 1, 0, 32'h0,     0, 0, 32'h100,   0, 0, 32'h0,     3);
        drive(1, 1, 0, 32'h0,     0, 0, 32'h100,   0, 0, 32'h0,     3);
        drive(1, 0, 1, 32'h1C,    0, 0, 32'h100,   1, 0, 32'h0,     3);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h1C,    1, 0, 32'h0,     4);
        drive(1, 0, 1, 32'h40,    1, 0, 32'h20,    1, 0, 32'h0,     5);
        drive(1, 0, 1, 32'h40,    0, 0, 32'h20,    0, 0, 32'h0,     5);
        drive(1, 0, 0, 32'h0,     1, 1, 32'h20,    0, 0, 32'h0,     5);
        drive(1, 0, 0, 32'h0,     0, 1, 32'h20,    0, 0, 32'h0,     5);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h20,    1, 0, 32'h0,     5);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h24,    1, 0, 32'h0,     6);
        drive(1, 0, 1, 32'h102,   0, 0, 32'h28,    1, 0, 32'h0,     7);
        for (int i = 0; i < 5; i++)
            drive(1, 1'($urandom), 1'($urandom), 32'($urandom_range(0, 255)) << 2, 1'($urandom), 1'($urandom),
                  32'h28, 0, 1, 32'h102, 7);
        drive(0, 0, 0, 32'h0,     0, 0, 32'h28,    0, 1, 32'h102,   7);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h0,     1, 0, 32'h0,     0);
        drive(1, 0, 1, 32'hFFC,   0, 0, 32'h4,     1, 0, 32'h0,     1);
        drive(1, 0, 0, 32'h0,     0, 0, 32'hFFC,   1, 0, 32'h0,     2);
        drive(1, 0, 0, 32'h0,     0, 0, 32'hFFC,   0, 1, 32'h1000,  2);
        drive(0, 0, 0, 32'h0,     0, 0, 32'hFFC,   0, 1, 32'h1000,  2);
        drive(1, 0, 1, 32'h1000,  0, 0, 32'h0,     1, 0, 32'h0,     0);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h1000,  0);
        drive(0, 1, 0, 32'h0,     0, 0, 32'h0,     0, 1, 32'h1000,  0);
        drive(1, 1, 0, 32'h0,     0, 0, 32'h0,     0, 0, 32'h0,     0);
        drive(1, 0, 0, 32'h0,     0, 0, 32'h0,     1, 0, 32'h0,     0);
        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", step, 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-sequencing stage directly upstream of `instructionMemory`. It holds the architectural PC and drives it as the byte address into the instruction memory each cycle. It advances the PC sequentially by 4, or loads a redirect target from the branch/jump logic, and honours stall and halt requests. Misaligned or out-of-range fetch addresses are trapped into a sticky fault state.

## Interface
Parameters:
- `WIDTH`, 32, address/data width; must match `instructionMemory`.
- `DEPTH`, 1024, instruction-memory depth in words; legal PC range is 0 to DEPTH*4-4.
- `RESET_PC`, 0, PC after reset; must be word-aligned and below DEPTH*4.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  synchronous active-low reset.
- `stall`  in  1  hold the PC this cycle.
- `redirect`  in  1  load `target` instead of PC+4.
- `target`  in  WIDTH  redirect byte address.
- `halt`  in  1  request entry to HALTED.
- `resume`  in  1  request exit from HALTED.
- `pc`  out  WIDTH  current PC; connects to `instructionMemory.addr`.
- `pc_plus4`  out  WIDTH  `pc + 4`, combinational, wraps modulo 2^WIDTH.
- `fetch_valid`  out  1  this cycle's `instr` is a real fetch.
- `fault`  out  1  sticky fetch fault.
- `fault_pc`  out  WIDTH  offending address captured on fault.
- `fetch_count`  out  32  number of accepted PC advances, saturating.

## Operation
- States: RUN, HALTED, FAULT.
- Reset (`rst_n`=0 at a clock edge) overrides everything:
  - `pc`=RESET_PC, state=RUN.
  - `fault`=0, `fault_pc`=0, `fetch_count`=0.
- `fetch_valid` = (state==RUN) & ~`stall`. It is combinational.
- RUN: per-cycle priority, highest first: `halt` > `redirect` > `stall` > sequential.
  - `halt`=1: PC holds and next state is HALTED. A same-cycle `redirect` is dropped.
  - `redirect`=1 with legal target: `pc`<=`target`. This overrides `stall`.
  - `redirect`=1 with illegal target: PC holds and next state is FAULT.
    - Illegal means `target[1:0]`!=0 or `target` >= DEPTH*4.
    - On entry, `fault_pc`<=`target` and `fault`<=1.
  - `stall`=1 without redirect: PC holds.
  - Sequential: `pc`<=`pc_plus4` if that address is below DEPTH*4.
    - Otherwise PC holds, next state is FAULT, and `fault_pc`<=`pc_plus4`. This covers the wrap-around case.
- `fetch_count` increments by 1 on every cycle in RUN where `pc` is actually loaded (sequential or legal redirect). It saturates at 0xFFFF_FFFF.
- HALTED:
  - PC holds and `redirect`/`stall` are ignored.
  - `resume`=1 and `halt`=0: next state is RUN with PC unchanged. Fetch restarts at the held PC.
  - `halt`=1 and `resume`=1: stays HALTED.
- FAULT:
  - Terminal until reset. PC, `fault_pc`, and `fetch_count` hold.
  - `fault`=1 and all inputs are ignored.

## Timing
- `pc`, state, `fault`, `fault_pc`, and `fetch_count` are registered. They update on the rising edge.
- A redirect asserted in cycle N is visible on `pc` in cycle N+1. `instr` from the combinational `instructionMemory` is valid in the same cycle.
- Stall has zero latency: `pc` is unchanged in N+1.
- Halt taken in cycle N: `fetch_valid`=0 from cycle N+1.
- Resume in cycle N: `fetch_valid`=1 in N+1, unless stalled.
- Fault detected in cycle N: `fault`=1 and `fault_pc` are valid in N+1. `fetch_valid`=0 from N+1.
- Reset mid-operation (any state): all registers return to reset values at the next edge. `fetch_valid` is 1 in the following cycle if `stall`=0.

## Test plan
- Reset, then 4 free-running cycles:
  - `pc` = 0x0, 0x4, 0x8, 0xC, 0x10.
  - `fetch_count`=4.
  - With backdoor-loaded imem, `instr` matches the shadow memory at each index.
- At `pc`=0x8, pulse `redirect` with `target`=0x100 and `stall`=1:
  - Next `pc`=0x100 (redirect beats stall).
  - Then `stall` alone for 2 cycles: `pc` stays 0x100 and `fetch_count` is unchanged.
- `halt`+`redirect`(0x40) together at `pc`=0x20:
  - HALTED, `pc`=0x20, `fetch_valid`=0, redirect dropped.
  - `resume` pulse: next cycle `fetch_valid`=1 and `pc`=0x20, then 0x24.
- `redirect` to 0x102:
  - `fault`=1 and `fault_pc`=0x102 next cycle.
  - `pc` is unchanged, and it stays frozen for 5 cycles of random inputs.
  - `rst_n`=0 for 1 cycle: `pc`=0, `fault`=0.
- Redirect to 0xFFC (DEPTH=1024), then run 1 cycle:
  - `fault`=1 and `fault_pc`=0x1000.
  - `pc` stays 0xFFC.
- Redirect to 0x1000:
  - Immediate fault with `fault_pc`=0x1000.
  - `fetch_count` does not increment for that cycle.
